// File: rtl/mysystem_spi_pkg.sv
// rtl/mysystem_spi_pkg.sv - register map, status bit positions and FSM encoding for the SPI shift master
package mysystem_spi_pkg;

   localparam logic [1:0] ADDR_TXDATA  = 2'd0;
   localparam logic [1:0] ADDR_RXDATA  = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_DIVIDER = 2'd3;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_RX_VALID = 1;
   localparam int STAT_RX_OVR   = 2;
   localparam int STAT_TX_OVR   = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4
   } spi_state_t;

   function automatic logic [31:0] status_word(input logic busy,
                                               input logic rx_valid,
                                               input logic rx_ovr,
                                               input logic tx_ovr);
      logic [31:0] w;
      w                = '0;
      w[STAT_BUSY]     = busy;
      w[STAT_RX_VALID] = rx_valid;
      w[STAT_RX_OVR]   = rx_ovr;
      w[STAT_TX_OVR]   = tx_ovr;
      return w;
   endfunction

endpackage

// File: rtl/mysystem_spi_clkdiv.sv
// rtl/mysystem_spi_clkdiv.sv - half-period tick generator, reload value latched at transfer start
module mysystem_spi_clkdiv #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DIV_W-1:0] div,
   input  logic             run,
   output logic             tick
);

   logic [DIV_W-1:0] reload_q;
   logic [DIV_W-1:0] count_q;

   // The reload value is captured only at start, so DIVIDER writes mid-transfer wait for the next word.
   always_ff @(posedge clk) begin
      if (reset) begin
         reload_q <= '0;
         count_q  <= '0;
      end else if (start) begin
         reload_q <= div;
         count_q  <= div;
      end else if (run) begin
         if (count_q == '0) begin
            count_q <= reload_q;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign tick = run && (count_q == '0);

endmodule

// File: rtl/mysystem_spi_shift_master.sv
// rtl/mysystem_spi_shift_master.sv - Avalon-MM SPI master, mode 0, MSB first
module mysystem_spi_shift_master
   import mysystem_spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic        spi_ss_n,
   input  logic        spi_miso
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   spi_state_t        state_q, state_d;
   logic [DIV_W-1:0]  div_q;
   logic [DATA_W-1:0] tx_sr_q, rx_sr_q, rx_data_q;
   logic [DATA_W-1:0] tx_shift, rx_shift;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [1:0]        miso_sync_q;
   logic              rx_valid_q, rx_ovr_q, tx_ovr_q;
   logic              tick, busy, start, sample, bit_done, done;
   logic              tx_wr, rx_rd, stat_wr, div_wr, rd_sel;
   logic [31:0]       rd_mux;
   logic              unused_wdata;

   assign tx_wr   = chipselect & write & (address == ADDR_TXDATA);
   assign stat_wr = chipselect & write & (address == ADDR_STATUS);
   assign div_wr  = chipselect & write & (address == ADDR_DIVIDER);
   assign rd_sel  = chipselect & read;
   assign rx_rd   = rd_sel & (address == ADDR_RXDATA);

   assign busy  = (state_q != ST_IDLE);
   assign start = tx_wr & ~busy;

   assign tx_shift = tx_sr_q << 1;
   assign rx_shift = (rx_sr_q << 1) | DATA_W'(miso_sync_q[1]);

   assign unused_wdata = ^writedata;

   mysystem_spi_clkdiv #(
      .DIV_W (DIV_W)
   ) u_clkdiv (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .div   (div_q),
      .run   (busy),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sample   = 1'b0;
      bit_done = 1'b0;
      done     = 1'b0;
      spi_sclk = 1'b0;
      spi_ss_n = 1'b1;
      spi_mosi = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            spi_ss_n = 1'b0;
            spi_mosi = tx_sr_q[DATA_W-1];
            if (tick) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            spi_ss_n = 1'b0;
            spi_sclk = 1'b1;
            spi_mosi = tx_sr_q[DATA_W-1];
            // Sampling on the last HIGH cycle leaves room for the synchroniser latency.
            if (tick) begin
               sample  = 1'b1;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            spi_ss_n = 1'b0;
            spi_mosi = tx_sr_q[DATA_W-1];
            if (tick) begin
               bit_done = 1'b1;
               state_d  = (bit_cnt_q == LAST_BIT) ? ST_HOLD : ST_HIGH;
            end
         end
         ST_HOLD: begin
            spi_ss_n = 1'b0;
            spi_mosi = tx_sr_q[DATA_W-1];
            if (tick) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         miso_sync_q <= '0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         bit_cnt_q   <= '0;
      end else begin
         miso_sync_q <= {miso_sync_q[0], spi_miso};
         if (start) begin
            tx_sr_q   <= writedata[DATA_W-1:0];
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
         end else begin
            if (sample) begin
               tx_sr_q <= tx_shift;
               rx_sr_q <= rx_shift;
            end
            if (bit_done) bit_cnt_q <= bit_cnt_q + 1'b1;
         end
      end
   end

   // Set events take priority over clears so a coincident overrun is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q      <= DIV_W'(DEFAULT_DIV);
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         tx_ovr_q   <= 1'b0;
      end else begin
         if (div_wr) div_q <= writedata[DIV_W-1:0];
         if (done) rx_data_q <= rx_sr_q;

         if (done) begin
            rx_valid_q <= 1'b1;
         end else if (rx_rd) begin
            rx_valid_q <= 1'b0;
         end

         if (done && rx_valid_q && !rx_rd) begin
            rx_ovr_q <= 1'b1;
         end else if (stat_wr) begin
            rx_ovr_q <= 1'b0;
         end

         if (tx_wr && busy) begin
            tx_ovr_q <= 1'b1;
         end else if (stat_wr) begin
            tx_ovr_q <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_RXDATA:  rd_mux = 32'(rx_data_q);
         ADDR_STATUS:  rd_mux = status_word(busy, rx_valid_q, rx_ovr_q, tx_ovr_q);
         ADDR_DIVIDER: rd_mux = 32'(div_q);
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         readdata <= rd_sel ? rd_mux : 32'd0;
      end
   end

endmodule

// File: tb/tb_mysystem_spi_shift_master.sv
// tb/tb_mysystem_spi_shift_master.sv - scoreboard bench for the SPI shift master
module tb_mysystem_spi_shift_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        spi_sclk, spi_mosi, spi_ss_n;
   logic        spi_miso;

   logic [1:0]  miso_mode = 2'd0;
   logic        miso_fixed = 1'b0;
   logic        mosi_d1 = 1'b0;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  sb[$];

   localparam int XFER_CYC = (2 * 8 + 2) * (4 + 1);

   mysystem_spi_shift_master dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_ss_n   (spi_ss_n),
      .spi_miso   (spi_miso)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mosi_d1 <= spi_mosi;

   // 0: loopback, 1: constant, 2: inverted loopback delayed one clock
   assign spi_miso = (miso_mode == 2'd0) ? spi_mosi :
                     (miso_mode == 2'd1) ? miso_fixed : ~mosi_d1;

   task automatic av_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic av_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (spi_ss_n !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (spi_ss_n !== 1'b1) begin
         bad++;
         $display("FAIL wait_done: ss_n=%b after %0d cycles, want 1", spi_ss_n, n);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      total++;
      if ({spi_ss_n, spi_sclk, spi_mosi} !== 3'b100) begin
         bad++;
         $display("FAIL reset_pins: ss_n/sclk/mosi=%b%b%b want 100", spi_ss_n, spi_sclk, spi_mosi);
      end
      total++;
      if (readdata !== 32'd0) begin
         bad++;
         $display("FAIL reset_readdata: got %h want 0", readdata);
      end
      av_read(2'd2, d);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL reset_status: got %h want 0", d); end
      av_read(2'd3, d);
      total++;
      if (d !== 32'd4) begin bad++; $display("FAIL reset_divider: got %h want 4", d); end
      av_read(2'd1, d);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL reset_rxdata: got %h want 0", d); end
   endtask

   task automatic test_loopback();
      logic [31:0] d;
      logic [7:0]  bits, e;
      logic        prev;
      int          low_cyc, pulses, hi_len, bad_len;
      bits = 8'd0; prev = 1'b0; low_cyc = 0; pulses = 0; hi_len = 0; bad_len = 0;
      miso_mode = 2'd0;
      av_write(2'd3, 32'd4);
      av_write(2'd0, 32'h0000_00A5);
      sb.push_back(8'hA5);
      while (spi_ss_n === 1'b0 && low_cyc < 1000) begin
         low_cyc++;
         if (spi_sclk && !prev) begin
            pulses++;
            bits   = {bits[6:0], spi_mosi};
            hi_len = 0;
         end
         if (spi_sclk) hi_len++;
         if (!spi_sclk && prev && hi_len != 5) bad_len++;
         prev = spi_sclk;
         @(negedge clk);
      end
      total++;
      if (low_cyc != XFER_CYC) begin bad++; $display("FAIL ss_low_len: got %0d want %0d", low_cyc, XFER_CYC); end
      total++;
      if (pulses != 8) begin bad++; $display("FAIL sclk_pulses: got %0d want 8", pulses); end
      total++;
      if (bad_len != 0) begin bad++; $display("FAIL sclk_high_len: %0d pulses not 5 cycles, want 0", bad_len); end
      total++;
      if (bits !== 8'hA5) begin bad++; $display("FAIL mosi_bits: got %h want a5", bits); end
      av_read(2'd2, d);
      total++;
      if (d !== 32'h2) begin bad++; $display("FAIL loop_status: got %h want 2", d); end
      av_read(2'd1, d);
      e = sb.pop_front();
      total++;
      if (d !== {24'd0, e}) begin bad++; $display("FAIL loop_rxdata: got %h want %h", d, e); end
   endtask

   task automatic test_rx_clear();
      logic [31:0] d;
      logic [7:0]  e;
      miso_mode = 2'd1; miso_fixed = 1'b1;
      av_write(2'd0, 32'h0);
      sb.push_back(8'hFF);
      wait_done();
      av_read(2'd1, d);
      e = sb.pop_front();
      total++;
      if (d !== {24'd0, e}) begin bad++; $display("FAIL ones_rxdata: got %h want %h", d, e); end
      av_read(2'd1, d);
      total++;
      if (d !== 32'hFF) begin bad++; $display("FAIL ones_reread: got %h want ff", d); end
      av_read(2'd2, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL rxvalid_cleared: status %h want 0", d); end
   endtask

   task automatic test_tx_overrun();
      logic [31:0] d;
      logic [7:0]  e;
      miso_mode = 2'd0;
      av_write(2'd0, 32'h3C);
      sb.push_back(8'h3C);
      repeat (10) @(negedge clk);
      av_write(2'd0, 32'h99);
      av_read(2'd2, d);
      total++;
      if (d !== 32'h9) begin bad++; $display("FAIL txovr_busy_status: got %h want 9", d); end
      wait_done();
      av_read(2'd2, d);
      total++;
      if (d !== 32'hA) begin bad++; $display("FAIL txovr_done_status: got %h want a", d); end
      av_write(2'd2, 32'h0);
      av_read(2'd2, d);
      total++;
      if (d !== 32'h2) begin bad++; $display("FAIL txovr_cleared: got %h want 2", d); end
      av_read(2'd1, d);
      e = sb.pop_front();
      total++;
      if (d !== {24'd0, e}) begin bad++; $display("FAIL txovr_rxdata: got %h want %h", d, e); end
   endtask

   task automatic test_rx_overrun();
      logic [31:0] d;
      logic [7:0]  e;
      int          low;
      miso_mode = 2'd0;
      av_write(2'd0, 32'h11);
      sb.push_back(8'h11);
      wait_done();
      av_write(2'd0, 32'h22);
      sb.push_back(8'h22);
      wait_done();
      av_read(2'd2, d);
      total++;
      if (d !== 32'h6) begin bad++; $display("FAIL rxovr_status: got %h want 6", d); end
      e = sb.pop_front();
      av_read(2'd1, d);
      e = sb.pop_front();
      total++;
      if (d !== {24'd0, e}) begin bad++; $display("FAIL rxovr_rxdata: got %h want %h", d, e); end
      av_write(2'd0, 32'h5A);
      sb.push_back(8'h5A);
      low = 1;
      while (low < XFER_CYC && spi_ss_n === 1'b0) begin
         @(negedge clk);
         low++;
      end
      chipselect = 1'b1; read = 1'b1; address = 2'd1;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      total++;
      if (readdata !== 32'h22) begin bad++; $display("FAIL coincident_read_old: got %h want 22", readdata); end
      total++;
      if (spi_ss_n !== 1'b1) begin bad++; $display("FAIL coincident_ss_n: got %b want 1", spi_ss_n); end
      av_read(2'd2, d);
      total++;
      if (d !== 32'h6) begin bad++; $display("FAIL coincident_status: got %h want 6", d); end
      av_read(2'd1, d);
      e = sb.pop_front();
      total++;
      if (d !== {24'd0, e}) begin bad++; $display("FAIL coincident_rxdata: got %h want %h", d, e); end
      av_write(2'd2, 32'h0);
   endtask

   task automatic test_mid_reset();
      logic [31:0] d;
      logic [7:0]  e;
      logic        prev;
      int          rises, n;
      prev = 1'b0; rises = 0; n = 0;
      miso_mode = 2'd0;
      av_write(2'd3, 32'd6);
      av_write(2'd0, 32'hF0);
      while (rises < 4 && n < 2000) begin
         @(negedge clk);
         n++;
         if (spi_sclk && !prev) rises++;
         prev = spi_sclk;
      end
      total++;
      if (rises != 4) begin bad++; $display("FAIL midreset_reach_bit3: rises %0d want 4", rises); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if ({spi_ss_n, spi_sclk} !== 2'b10) begin
         bad++;
         $display("FAIL midreset_pins: ss_n/sclk=%b%b want 10", spi_ss_n, spi_sclk);
      end
      av_read(2'd2, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL midreset_status: got %h want 0", d); end
      av_read(2'd3, d);
      total++;
      if (d !== 32'd4) begin bad++; $display("FAIL midreset_divider: got %h want 4", d); end
      av_write(2'd0, 32'h81);
      sb.push_back(8'h81);
      wait_done();
      av_read(2'd1, d);
      e = sb.pop_front();
      total++;
      if (d !== {24'd0, e}) begin bad++; $display("FAIL midreset_rxdata: got %h want %h", d, e); end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [7:0]  tx, e;
      av_write(2'd3, 32'd2);
      miso_mode = 2'd2;
      for (int i = 0; i < 200; i++) begin
         tx = 8'($urandom_range(0, 255));
         av_write(2'd0, {24'd0, tx});
         sb.push_back(~tx);
         wait_done();
         av_read(2'd1, d);
         e = sb.pop_front();
         total++;
         if (d !== {24'd0, e}) begin
            bad++;
            $display("FAIL random_rxdata[%0d]: tx %h got %h want %h", i, tx, d, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_rx_clear();
      test_tx_overrun();
      test_rx_overrun();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
